// File: rtl/seq_play_pkg.sv
// Shared types for the symbol-playback sequencer (seq_play_ctrl and seq_play_mem).
package seq_play_pkg;

   typedef enum logic [1:0] {
      K_VAL  = 2'd0,
      K_X    = 2'd1,
      K_Z    = 2'd2,
      K_HOLD = 2'd3
   } kind_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   typedef struct packed {
      kind_e      kind;
      logic [3:0] val;
   } sym_t;

   localparam int SYM_W = $bits(sym_t);

endpackage

// File: rtl/seq_play_mem.sv
// Symbol store: DEPTH x sym_t flop array, one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a loaded pattern survives a controller reset.
module seq_play_mem
   import seq_play_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  sym_t                     wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output sym_t                     rdata_o
);

   sym_t mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/seq_play_ctrl.sv
// Runtime-programmable stimulus sequencer: plays a loaded symbol memory onto dout, one per cycle.
// Optional consumer stall input is compiled in when SEQ_PLAY_STALL_EN is defined.
module seq_play_ctrl
   import seq_play_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int N     = 4,
   parameter int LOOPW = 8
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [5:0]               wr_data,
   output logic                     wr_err,
   input  logic                     start,
   input  logic                     stop,
`ifdef SEQ_PLAY_STALL_EN
   input  logic                     stall,
`endif
   input  logic [$clog2(DEPTH):0]   len,
   input  logic [LOOPW-1:0]         loops,
   output wire  [N-1:0]             dout,
   output logic                     dout_vld,
   output logic                     busy,
   output logic                     done,
   output logic [LOOPW-1:0]         pass_cnt,
   output state_e                   dbg_state
);

   localparam int AW = $clog2(DEPTH);

   state_e           state_q;
   logic [AW-1:0]    ptr_q, last_q, rd_addr;
   logic [LOOPW-1:0] pass_q, loops_q;
   logic [N-1:0]     dout_q, dout_d;
   logic             dz_q, dz_d, vld_q, wr_err_q;
   logic             mem_we, stall_w, at_last, finish;
   logic [AW:0]      len_cl;
   sym_t             rd_sym, sym_nx, wr_sym;

`ifdef SEQ_PLAY_STALL_EN
   assign stall_w = stall;
`else
   assign stall_w = 1'b0;
`endif

   assign wr_sym  = sym_t'(wr_data);
   assign mem_we  = wr_en && (state_q == S_IDLE);
   assign at_last = (ptr_q == last_q);
   assign finish  = (pass_q == loops_q) && (loops_q != '1);

   seq_play_mem #(.DEPTH(DEPTH)) u_mem (
      .clk_i   (clock),
      .we_i    (mem_we),
      .waddr_i (wr_addr),
      .wdata_i (wr_sym),
      .raddr_i (rd_addr),
      .rdata_o (rd_sym)
   );

   always_comb begin
      len_cl = len;
      if (len > (AW+1)'(DEPTH)) begin
         len_cl = (AW+1)'(DEPTH);
      end
   end

   // Read the symbol that will be shown after the coming edge; a write on the start edge is forwarded.
   always_comb begin
      rd_addr = '0;
      if (state_q == S_PLAY && !at_last) begin
         rd_addr = ptr_q + AW'(1);
      end
      sym_nx = (mem_we && (wr_addr == rd_addr)) ? wr_sym : rd_sym;
   end

   always_comb begin
      dout_d = dout_q;
      dz_d   = dz_q;
      case (sym_nx.kind)
         K_VAL: begin
            dout_d = sym_nx.val[N-1:0];
            dz_d   = 1'b0;
         end
         K_X: begin
            dout_d = 'x;
            dz_d   = 1'b0;
         end
         K_Z:     dz_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         last_q   <= '0;
         pass_q   <= '0;
         loops_q  <= '0;
         dout_q   <= '0;
         dz_q     <= 1'b0;
         vld_q    <= 1'b0;
         wr_err_q <= 1'b0;
      end else begin
         wr_err_q <= wr_en && (state_q != S_IDLE);
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  ptr_q   <= '0;
                  pass_q  <= '0;
                  last_q  <= AW'(len_cl - (AW+1)'(1));
                  loops_q <= loops;
                  if (len == '0) begin
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_PLAY;
                     dout_q  <= dout_d;
                     dz_q    <= dz_d;
                     vld_q   <= 1'b1;
                  end
               end
            end
            S_PLAY: begin
               if (stop || (!stall_w && at_last && finish)) begin
                  state_q <= S_DONE;
                  dout_q  <= '0;
                  dz_q    <= 1'b0;
                  vld_q   <= 1'b0;
               end else if (!stall_w) begin
                  dout_q <= dout_d;
                  dz_q   <= dz_d;
                  if (at_last) begin
                     ptr_q  <= '0;
                     pass_q <= pass_q + LOOPW'(1);
                  end else begin
                     ptr_q <= ptr_q + AW'(1);
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // dout_vld qualifies dout every cycle it is high; there is no back-pressure other than stall.
   assign dout      = dz_q ? {N{1'bz}} : dout_q;
   assign dout_vld  = vld_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign wr_err    = wr_err_q;
   assign pass_cnt  = pass_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_play_ctrl.sv
// Bench for seq_play_ctrl: random patterns against a list-based playback model (X/Z values are not value-checked).
module tb_seq_play_ctrl;

   localparam int DEPTH = 64;
   localparam int N     = 4;
   localparam int LOOPW = 8;
   localparam int AW    = $clog2(DEPTH);

   logic             clock = 1'b0;
   logic             resetn = 1'b0;
   logic             wr_en = 1'b0;
   logic [AW-1:0]    wr_addr = '0;
   logic [5:0]       wr_data = '0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic [AW:0]      len = '0;
   logic [LOOPW-1:0] loops = '0;
   wire  [N-1:0]     dout;
   logic             wr_err, dout_vld, busy, done;
   logic [LOOPW-1:0] pass_cnt;
   seq_play_pkg::state_e dbg_state;
`ifdef SEQ_PLAY_STALL_EN
   logic             stall = 1'b0;
`endif

   logic [5:0]       mdl_mem [DEPTH];
   logic [N-1:0]     exp_q[$];
   bit               exp_k_q[$];
   logic [LOOPW-1:0] exp_p_q[$];
   int               total = 0;
   int               bad = 0;

   always #5 clock = ~clock;

   seq_play_ctrl #(.DEPTH(DEPTH), .N(N), .LOOPW(LOOPW)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_err    (wr_err),
      .start     (start),
      .stop      (stop),
`ifdef SEQ_PLAY_STALL_EN
      .stall     (stall),
`endif
      .len       (len),
      .loops     (loops),
      .dout      (dout),
      .dout_vld  (dout_vld),
      .busy      (busy),
      .done      (done),
      .pass_cnt  (pass_cnt),
      .dbg_state (dbg_state)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr_sym(input logic [AW-1:0] a, input logic [5:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_en = 1'b0;
      mdl_mem[a] = d;
   endtask

   task automatic launch(input int l, input int lp);
      len   = (AW+1)'(l);
      loops = LOOPW'(lp);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Expected played stream: passes x clamped length, HOLD repeats the last value, X/Z make it unknown.
   function automatic void build_exp(input int len_v, input int loops_v, input int max_syms);
      int         l;
      logic [N-1:0] prev;
      bit         pk;
      l    = (len_v > DEPTH) ? DEPTH : len_v;
      prev = '0;
      pk   = 1'b1;
      exp_q.delete();
      exp_k_q.delete();
      exp_p_q.delete();
      for (int p = 0; p <= loops_v; p++) begin
         for (int i = 0; i < l; i++) begin
            if (exp_q.size() >= max_syms) return;
            case (mdl_mem[i][5:4])
               2'd0: begin prev = mdl_mem[i][N-1:0]; pk = 1'b1; end
               2'd1, 2'd2: pk = 1'b0;
               default: ;
            endcase
            exp_q.push_back(prev);
            exp_k_q.push_back(pk);
            exp_p_q.push_back(LOOPW'(p));
         end
      end
   endfunction

   task automatic test_reset();
      repeat (2) @(posedge clock);
      #1;
      total++;
      if (dout !== '0 || dout_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_out: dout=%h vld=%b busy=%b done=%b want all 0", dout, dout_vld, busy, done);
      end
      total++;
      if (wr_err !== 1'b0 || pass_cnt !== '0) begin
         bad++;
         $display("FAIL reset_cnt: wr_err=%b pass=%0d want 0 0", wr_err, pass_cnt);
      end
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      wr_sym(0, 6'h01);
      wr_sym(1, 6'h02);
      wr_sym(2, 6'h03);
      build_exp(3, 0, 1000);
      launch(3, 0);
      for (int i = 0; i < 3; i++) begin
         total++;
         if (dout_vld !== 1'b1 || dout !== exp_q[i] || pass_cnt !== exp_p_q[i] || done !== 1'b0) begin
            bad++;
            $display("FAIL basic_sym%0d: vld=%b dout=%h pass=%0d done=%b want 1 %h %0d 0",
                     i, dout_vld, dout, pass_cnt, done, exp_q[i], exp_p_q[i]);
         end
         tick();
      end
      total++;
      if (done !== 1'b1 || dout_vld !== 1'b0 || busy !== 1'b1 || dout !== '0) begin
         bad++;
         $display("FAIL basic_done: done=%b vld=%b busy=%b dout=%h want 1 0 1 0", done, dout_vld, busy, dout);
      end
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL basic_idle: busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_loops();
      wr_sym(0, {2'd0, 4'($urandom_range(0, 15))});
      wr_sym(1, {2'd0, 4'($urandom_range(0, 15))});
      build_exp(2, 2, 1000);
      launch(2, 2);
      for (int i = 0; i < 6; i++) begin
         total++;
         if (dout_vld !== 1'b1 || dout !== exp_q[i] || pass_cnt !== exp_p_q[i] || done !== 1'b0) begin
            bad++;
            $display("FAIL loops_sym%0d: vld=%b dout=%h pass=%0d done=%b want 1 %h %0d 0",
                     i, dout_vld, dout, pass_cnt, done, exp_q[i], exp_p_q[i]);
         end
         tick();
      end
      total++;
      if (done !== 1'b1 || dout_vld !== 1'b0) begin
         bad++;
         $display("FAIL loops_done: done=%b vld=%b want 1 0", done, dout_vld);
      end
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL loops_single_done: done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_stop_infinite();
      for (int a = 0; a < 3; a++) wr_sym(AW'(a), {2'd0, 4'($urandom_range(0, 15))});
      build_exp(3, 1000, 7);
      launch(3, (1 << LOOPW) - 1);
      for (int i = 0; i < 7; i++) begin
         total++;
         if (dout_vld !== 1'b1 || dout !== exp_q[i] || pass_cnt !== exp_p_q[i]) begin
            bad++;
            $display("FAIL inf_sym%0d: vld=%b dout=%h pass=%0d want 1 %h %0d",
                     i, dout_vld, dout, pass_cnt, exp_q[i], exp_p_q[i]);
         end
         stop = (i == 6);
         tick();
      end
      stop = 1'b0;
      total++;
      if (done !== 1'b1 || dout_vld !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL inf_stop: done=%b vld=%b busy=%b want 1 0 1", done, dout_vld, busy);
      end
      tick();
      total++;
      if (busy !== 1'b0 || dout_vld !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL inf_after: busy=%b vld=%b done=%b want 0 0 0", busy, dout_vld, done);
      end
   endtask

   task automatic test_kinds();
      wr_sym(0, 6'h05);
      wr_sym(1, 6'h10);
      wr_sym(2, 6'h20);
      wr_sym(3, 6'h30);
      build_exp(4, 0, 1000);
      launch(4, 0);
      for (int i = 0; i < 4; i++) begin
         total++;
         if (dout_vld !== 1'b1 || (exp_k_q[i] && dout !== exp_q[i])) begin
            bad++;
            $display("FAIL kinds_sym%0d: vld=%b dout=%h want 1 %h", i, dout_vld, dout, exp_q[i]);
         end
         if (i == 1) begin
            total++;
            if (wr_err !== 1'b1) begin
               bad++;
               $display("FAIL kinds_wr_err: got %b want 1", wr_err);
            end
         end
         wr_en   = (i == 0);
         wr_addr = '0;
         wr_data = 6'h09;
         tick();
      end
      wr_en = 1'b0;
      tick();
      build_exp(1, 0, 1000);
      launch(1, 0);
      total++;
      if (dout_vld !== 1'b1 || dout !== exp_q[0]) begin
         bad++;
         $display("FAIL kinds_mem_kept: vld=%b dout=%h want 1 %h", dout_vld, dout, exp_q[0]);
      end
      repeat (2) tick();
   endtask

   task automatic test_len_edges();
      launch(0, 0);
      total++;
      if (done !== 1'b1 || dout_vld !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL len0: done=%b vld=%b busy=%b want 1 0 1", done, dout_vld, busy);
      end
      tick();
      for (int a = 0; a < DEPTH; a++) wr_sym(AW'(a), 6'($urandom_range(0, 63)));
      build_exp(DEPTH + 5, 0, 1000);
      launch(DEPTH + 5, 0);
      for (int i = 0; i < DEPTH; i++) begin
         total++;
         if (dout_vld !== 1'b1 || (exp_k_q[i] && dout !== exp_q[i]) || done !== 1'b0) begin
            bad++;
            $display("FAIL clamp_sym%0d: vld=%b dout=%h done=%b want 1 %h 0", i, dout_vld, dout, done, exp_q[i]);
         end
         tick();
      end
      total++;
      if (done !== 1'b1 || dout_vld !== 1'b0) begin
         bad++;
         $display("FAIL clamp_done: done=%b vld=%b want 1 0", done, dout_vld);
      end
      tick();
   endtask

   task automatic test_same_edge();
      logic [5:0] d;
      d       = {2'd0, 4'(mdl_mem[0][3:0] + 4'd1)};
      wr_en   = 1'b1;
      wr_addr = '0;
      wr_data = d;
      len     = 1;
      loops   = '0;
      start   = 1'b1;
      tick();
      wr_en = 1'b0;
      start = 1'b0;
      mdl_mem[0] = d;
      total++;
      if (dout_vld !== 1'b1 || dout !== d[N-1:0] || wr_err !== 1'b0) begin
         bad++;
         $display("FAIL same_edge: vld=%b dout=%h wr_err=%b want 1 %h 0", dout_vld, dout, wr_err, d[N-1:0]);
      end
      repeat (2) tick();
   endtask

   task automatic test_reset_mid();
      build_exp(10, 0, 1000);
      launch(10, 0);
      repeat (3) tick();
      resetn = 1'b0;
      #1;
      total++;
      if (dout !== '0 || dout_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass_cnt !== '0) begin
         bad++;
         $display("FAIL rst_mid: dout=%h vld=%b busy=%b done=%b pass=%0d want all 0",
                  dout, dout_vld, busy, done, pass_cnt);
      end
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_nodone: done=%b busy=%b want 0 0", done, busy);
      end
      resetn = 1'b1;
      tick();
      launch(10, 0);
      for (int i = 0; i < 10; i++) begin
         total++;
         if (dout_vld !== 1'b1 || (exp_k_q[i] && dout !== exp_q[i])) begin
            bad++;
            $display("FAIL rst_mem_sym%0d: vld=%b dout=%h want 1 %h", i, dout_vld, dout, exp_q[i]);
         end
         tick();
      end
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL rst_mem_done: done=%b want 1", done);
      end
      tick();
   endtask

`ifdef SEQ_PLAY_STALL_EN
   task automatic test_stall();
      for (int a = 0; a < 5; a++) wr_sym(AW'(a), {2'd0, 4'($urandom_range(0, 15))});
      build_exp(5, 0, 1000);
      launch(5, 0);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (dout_vld !== 1'b1 || dout !== exp_q[i]) begin
            bad++;
            $display("FAIL stall_sym%0d: vld=%b dout=%h want 1 %h", i, dout_vld, dout, exp_q[i]);
         end
         if (i == 1) begin
            stall = 1'b1;
            for (int s = 0; s < 3; s++) begin
               tick();
               total++;
               if (dout_vld !== 1'b1 || dout !== exp_q[1] || pass_cnt !== '0) begin
                  bad++;
                  $display("FAIL stall_hold%0d: vld=%b dout=%h want 1 %h", s, dout_vld, dout, exp_q[1]);
               end
            end
            stall = 1'b0;
         end
         tick();
      end
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL stall_done: done=%b want 1", done);
      end
      tick();
   endtask
`endif

   task automatic test_random();
      for (int t = 0; t < 8; t++) begin
         int l, lp, n, stop_i, last_i;
         l  = $urandom_range(1, 8);
         lp = $urandom_range(0, 3);
         n  = l * (lp + 1);
         for (int a = 0; a < 8; a++) wr_sym(AW'(a), 6'($urandom_range(0, 63)));
         stop_i = $urandom_range(0, n + 3);
         if (stop_i >= n) stop_i = -1;
         last_i = (stop_i >= 0) ? stop_i : n - 1;
         build_exp(l, lp, 1000);
         launch(l, lp);
         for (int i = 0; i <= last_i; i++) begin
            total++;
            if (dout_vld !== 1'b1 || (exp_k_q[i] && dout !== exp_q[i]) || pass_cnt !== exp_p_q[i]) begin
               bad++;
               $display("FAIL rnd%0d_sym%0d: vld=%b dout=%h pass=%0d want 1 %h %0d",
                        t, i, dout_vld, dout, pass_cnt, exp_q[i], exp_p_q[i]);
            end
            stop = (i == stop_i);
            tick();
         end
         stop = 1'b0;
         total++;
         if (done !== 1'b1 || dout_vld !== 1'b0 || dout !== '0) begin
            bad++;
            $display("FAIL rnd%0d_done: done=%b vld=%b dout=%h want 1 0 0", t, done, dout_vld, dout);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_loops();
      test_stop_infinite();
      test_kinds();
      test_len_edges();
      test_same_edge();
      test_reset_mid();
`ifdef SEQ_PLAY_STALL_EN
      test_stall();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
